axis_pixel_packer: RTL
======================

Name: axis_pixel_packer

Overview:
- Drain-side consumer for the 8-bit processed-pixel output FIFO.
- Accepts one 8-bit pixel per handshake on a slave AXI-Stream port and packs four pixels into one 32-bit beat on a master AXI-Stream port.
- Marks the last beat of each frame with tlast and tkeep, and pulses frame_done when that beat completes.
- Sits between the output FIFO's master port and the DMA/interconnect write path.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame; FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT, which must be >= 1.
- CNT_WIDTH, 18, width of the pixel counter; must satisfy 2^CNT_WIDTH >= FRAME_PIXELS.

Ports:
- s_aclk  in  1  sole clock; all logic on rising edge.
- s_areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  pixel valid from the FIFO.
- s_axis_tready  out  1  packer can accept a pixel.
- s_axis_tdata  in  8  pixel.
- m_axis_tvalid  out  1  packed beat valid.
- m_axis_tready  in  1  downstream accepts the beat.
- m_axis_tdata  out  32  packed pixels.
- m_axis_tkeep  out  4  byte-valid mask.
- m_axis_tlast  out  1  beat holds the last pixel of the frame.
- frame_done  out  1  one-cycle pulse when the tlast beat handshakes.
- pix_count  out  CNT_WIDTH  pixels accepted so far in the current frame.

Behaviour:
- Reset: while s_areset is high at a clock edge, the following clear to 0:
  - byte_idx, pix_count, accumulator, output register.
  - m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_done.
  - Reset mid-frame discards partial data; no tlast is emitted for the aborted frame.
- Handshakes: in = s_axis_tvalid & s_axis_tready; out = m_axis_tvalid & m_axis_tready.
- Byte order: the first pixel of a beat goes to bits [7:0], the second to [15:8], and so on.
- completing = (byte_idx==3) | (pix_count==FRAME_PIXELS-1).
- s_axis_tready (combinational) = !completing | !m_axis_tvalid | m_axis_tready.
  - Bytes 0-2 of a beat are always accepted, even while the output is stalled.
  - The closing byte waits for the output register to be free or draining.
- On in with !completing:
  - write the byte into the accumulator at byte_idx;
  - byte_idx += 1;
  - pix_count += 1.
- On in with completing:
  - Load the output register: data = accumulator with the current byte merged at byte_idx; unused upper bytes = 0.
  - tkeep = mask of bytes 0..byte_idx.
  - tlast = (pix_count==FRAME_PIXELS-1).
  - m_axis_tvalid <= 1.
  - byte_idx <= 0; the accumulator clears.
  - pix_count <= 0 if tlast, else pix_count+1.
- Full beats have tkeep=4'hF. Only the final beat of a frame may be partial; e.g. FRAME_PIXELS%4==2 gives tkeep=4'h3.
- On out without a new load: m_axis_tvalid <= 0.
- On out with a simultaneous load: the register reloads and m_axis_tvalid stays 1, giving back-to-back beats.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tkeep and tlast hold stable.
- Latency: the beat is valid the cycle after the closing byte's handshake.
- Throughput: 1 pixel/cycle sustained when m_axis_tready=1.
- frame_done is registered: high the cycle after out with m_axis_tlast=1; otherwise 0.
- Wrap-around: pix_count never reaches FRAME_PIXELS; it returns to 0 at the end of each frame and the next frame starts with byte_idx=0.

Optional Feature:
- Macro: AXIS_PACKER_SOF_EN.
- Defined: adds output port m_axis_tuser (1 bit).
  - It is 1 on the first beat of every frame: the beat that holds the pixel accepted when pix_count==0.
  - It is registered with the beat and held stable under backpressure.
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, m_axis_tready=1; stream bytes 01..08 continuously -> 2 beats:
  - beat 1: 32'h04030201, tkeep=F, tlast=0;
  - beat 2: 32'h08070605, tkeep=F, tlast=1;
  - frame_done pulses one cycle after beat 2; pix_count returns to 0.
- IMG_WIDTH=3, IMG_HEIGHT=2; stream bytes 11..16 -> beats:
  - beat 1: 32'h14131211, tkeep=F;
  - beat 2: 32'h00001615, tkeep=3, tlast=1.
- 8-pixel frame, m_axis_tready=0 for 10 cycles after the first beat:
  - bytes 05,06,07 are accepted; s_axis_tready=0 at byte 08;
  - tdata holds 32'h04030201 throughout the stall;
  - after ready rises, both beats arrive in order with no loss or duplication.
- Two back-to-back 8-pixel frames with ready=1 -> 4 beats with no bubble; tlast on beats 2 and 4; two frame_done pulses.
- Assert s_areset after 6 pixels of an 8-pixel frame, then send a fresh frame:
  - outputs are 0 the cycle after reset;
  - the new frame's first beat carries its own first 4 pixels, and tlast falls only at its 8th pixel.
- With AXIS_PACKER_SOF_EN defined, two 8-pixel frames -> m_axis_tuser=1 on beats 1 and 3 only; 0 on beats 2 and 4.

Source files
------------

// File: rtl/axis_pixel_packer.sv
// -----------------------------------------------------------------------------
// axis_pixel_packer
//
// Purpose:
//   Drain-side consumer for the 8-bit processed-pixel output FIFO. Accepts one
//   pixel per slave AXI-Stream handshake and packs four pixels into one 32-bit
//   master AXI-Stream beat (first pixel in bits [7:0]). The beat holding the
//   last pixel of a frame carries tlast and a tkeep mask covering only the
//   bytes actually used. frame_done pulses the cycle after that beat
//   handshakes.
//
// Parameters:
//   IMG_WIDTH   pixels per line
//   IMG_HEIGHT  lines per frame (IMG_WIDTH*IMG_HEIGHT must be >= 1)
//   CNT_WIDTH   pixel counter width, 2**CNT_WIDTH >= IMG_WIDTH*IMG_HEIGHT
//
// Ports:
//   s_aclk         in   sole clock, rising edge
//   s_areset       in   synchronous active-high reset
//   s_axis_tvalid  in   pixel valid from the FIFO
//   s_axis_tready  out  packer can accept a pixel (combinational)
//   s_axis_tdata   in   [7:0] pixel
//   m_axis_tvalid  out  packed beat valid
//   m_axis_tready  in   downstream accepts the beat
//   m_axis_tdata   out  [31:0] packed pixels
//   m_axis_tkeep   out  [3:0] byte-valid mask
//   m_axis_tlast   out  beat holds the last pixel of the frame
//   m_axis_tuser   out  first beat of a frame (only with AXIS_PACKER_SOF_EN)
//   frame_done     out  one-cycle pulse after the tlast beat handshakes
//   pix_count      out  [CNT_WIDTH-1:0] pixels accepted in the current frame
//
// Build option:
//   AXIS_PACKER_SOF_EN  when defined, adds m_axis_tuser (start-of-frame flag).
// -----------------------------------------------------------------------------
module axis_pixel_packer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int CNT_WIDTH  = 18
) (
  input  logic                 s_aclk,
  input  logic                 s_areset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [7:0]           s_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic [3:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
`ifdef AXIS_PACKER_SOF_EN
  output logic                 m_axis_tuser,
`endif
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] pix_count
);

  localparam int                   FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [CNT_WIDTH-1:0] LAST_PIX     = CNT_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  // Byte-valid mask covering lanes 0..idx of the beat being closed.
  function automatic logic [3:0] keep_mask(input logic [1:0] idx);
    logic [3:0] mask;
    case (idx)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b0111;
      2'd3:    mask = 4'b1111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Place a pixel into its byte lane; other lanes are zero.
  function automatic logic [31:0] lane_place(input logic [7:0] pix, input logic [1:0] idx);
    logic [31:0] word;
    case (idx)
      2'd0:    word = {24'h00_0000, pix};
      2'd1:    word = {16'h0000, pix, 8'h00};
      2'd2:    word = {8'h00, pix, 16'h0000};
      2'd3:    word = {pix, 24'h00_0000};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Input-side state
  logic [1:0]           byte_idx_r;
  logic [1:0]           byte_idx_nxt_s;
  logic [CNT_WIDTH-1:0] pix_count_r;
  logic [CNT_WIDTH-1:0] pix_count_nxt_s;
  logic [31:0]          acc_r;
  logic [31:0]          acc_nxt_s;

  // Output register
  logic                 tvalid_r;
  logic                 tvalid_nxt_s;
  logic [31:0]          tdata_r;
  logic [31:0]          tdata_nxt_s;
  logic [3:0]           tkeep_r;
  logic [3:0]           tkeep_nxt_s;
  logic                 tlast_r;
  logic                 tlast_nxt_s;
  logic                 frame_done_r;
  logic                 frame_done_nxt_s;

  // Handshake / control terms
  logic                 last_pix_s;
  logic                 completing_s;
  logic                 ready_s;
  logic                 in_hs_s;
  logic                 out_hs_s;
  logic                 load_s;
  logic [31:0]          merged_s;

`ifdef AXIS_PACKER_SOF_EN
  logic                 tuser_r;
  logic                 tuser_nxt_s;
  logic                 first_beat_s;
`endif

  // Handshake decode and the closing-byte back-pressure rule.
  always_comb begin
    last_pix_s   = (pix_count_r == LAST_PIX);
    completing_s = (byte_idx_r == 2'd3) || last_pix_s;
    // Bytes that do not close a beat go into the accumulator, which never
    // stalls; only the closing byte needs the output register free/draining.
    ready_s      = !completing_s || !tvalid_r || m_axis_tready;
    in_hs_s      = s_axis_tvalid && ready_s;
    out_hs_s     = tvalid_r && m_axis_tready;
    load_s       = in_hs_s && completing_s;
    // The accumulator is cleared per beat, so unused upper lanes stay zero.
    merged_s     = acc_r | lane_place(s_axis_tdata, byte_idx_r);
  end

`ifdef AXIS_PACKER_SOF_EN
  // Frames always start at lane 0, so pix_count equals byte_idx only while
  // filling the first beat of a frame (later beats have pix_count >= 4).
  always_comb begin
    first_beat_s = (pix_count_r == CNT_WIDTH'(byte_idx_r));
  end
`endif

  // Accumulator, byte index and pixel counter next-state.
  always_comb begin
    byte_idx_nxt_s  = byte_idx_r;
    pix_count_nxt_s = pix_count_r;
    acc_nxt_s       = acc_r;
    if (load_s) begin
      byte_idx_nxt_s = 2'd0;
      acc_nxt_s      = 32'h0000_0000;
      if (last_pix_s) begin
        pix_count_nxt_s = {CNT_WIDTH{1'b0}};
      end else begin
        pix_count_nxt_s = pix_count_r + CNT_ONE;
      end
    end else if (in_hs_s) begin
      byte_idx_nxt_s  = byte_idx_r + 2'd1;
      pix_count_nxt_s = pix_count_r + CNT_ONE;
      acc_nxt_s       = merged_s;
    end else begin
      byte_idx_nxt_s  = byte_idx_r;
      pix_count_nxt_s = pix_count_r;
      acc_nxt_s       = acc_r;
    end
  end

  // Output register next-state: reload on a closing byte, otherwise hold
  // until the beat is taken.
  always_comb begin
    tvalid_nxt_s     = tvalid_r;
    tdata_nxt_s      = tdata_r;
    tkeep_nxt_s      = tkeep_r;
    tlast_nxt_s      = tlast_r;
    frame_done_nxt_s = out_hs_s && tlast_r;
    if (load_s) begin
      // A load in the same cycle as a drain keeps tvalid high: back-to-back.
      tvalid_nxt_s = 1'b1;
      tdata_nxt_s  = merged_s;
      tkeep_nxt_s  = keep_mask(byte_idx_r);
      tlast_nxt_s  = last_pix_s;
    end else if (out_hs_s) begin
      tvalid_nxt_s = 1'b0;
    end else begin
      tvalid_nxt_s = tvalid_r;
    end
  end

`ifdef AXIS_PACKER_SOF_EN
  // Start-of-frame flag travels with the beat it describes.
  always_comb begin
    tuser_nxt_s = tuser_r;
    if (load_s) begin
      tuser_nxt_s = first_beat_s;
    end else begin
      tuser_nxt_s = tuser_r;
    end
  end
`endif

  // State registers with synchronous reset; reset discards any partial beat.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      byte_idx_r   <= 2'd0;
      pix_count_r  <= {CNT_WIDTH{1'b0}};
      acc_r        <= 32'h0000_0000;
      tvalid_r     <= 1'b0;
      tdata_r      <= 32'h0000_0000;
      tkeep_r      <= 4'h0;
      tlast_r      <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      byte_idx_r   <= byte_idx_nxt_s;
      pix_count_r  <= pix_count_nxt_s;
      acc_r        <= acc_nxt_s;
      tvalid_r     <= tvalid_nxt_s;
      tdata_r      <= tdata_nxt_s;
      tkeep_r      <= tkeep_nxt_s;
      tlast_r      <= tlast_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

`ifdef AXIS_PACKER_SOF_EN
  // Start-of-frame flag register.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      tuser_r <= 1'b0;
    end else begin
      tuser_r <= tuser_nxt_s;
    end
  end

  assign m_axis_tuser = tuser_r;
`endif

  assign s_axis_tready = ready_s;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tkeep  = tkeep_r;
  assign m_axis_tlast  = tlast_r;
  assign frame_done    = frame_done_r;
  assign pix_count     = pix_count_r;

endmodule
